dm_write_handler: RTL and testbench



---
 rtl/dm_write_handler_if.sv | 33 +++
 rtl/dm_write_handler.sv | 141 ++++++++++++++
 tb/tb_dm_write_handler.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_write_handler_if.sv
// Store-request bundle between the write arbiter and the data-memory write
// handler, plus the byte-wide RAM write port driven by the handler.
//
// Handshake: the requester holds wr_ins high with stable data/address/type.
// The handler accepts on a rising edge where it is idle (wr_idle=1).
// While busy (wr_idle=0), wr_ins is ignored and nothing is queued.
interface dm_write_handler_if #(
    parameter int DOUBLEWORD_WIDTH = 64,
    parameter int ADDR_WIDTH_DM    = 10,
    parameter int DATA_TYPE_WIDTH  = 2
);
    logic [DOUBLEWORD_WIDTH-1:0] data_bus_wr;
    logic [ADDR_WIDTH_DM-1:0]    addr_wr;
    logic [DATA_TYPE_WIDTH-1:0]  data_type_wr;
    logic                        wr_ins;
    logic                        wr_idle;
    logic                        mem_wr_en;
    logic [ADDR_WIDTH_DM-1:0]    mem_addr;
    logic [7:0]                  mem_wdata;
    logic                        wr_done;

    // Requester side (arbiter); also observes the RAM port.
    modport master (
        output data_bus_wr, addr_wr, data_type_wr, wr_ins,
        input  wr_idle, mem_wr_en, mem_addr, mem_wdata, wr_done
    );

    // Handler side.
    modport slave (
        input  data_bus_wr, addr_wr, data_type_wr, wr_ins,
        output wr_idle, mem_wr_en, mem_addr, mem_wdata, wr_done
    );
endinterface

// File: rtl/dm_write_handler.sv
// Data-memory write handler: accepts one store (byte/half/word/doubleword)
// and serialises it little-endian onto a byte-wide RAM write port, one byte
// per cycle, wrapping at the top of memory.
// Optional macro DM_WR_ALIGN_CHECK_EN: rejects stores whose address is not a
// multiple of the access size and flags them on wr_misalign for one cycle.
module dm_write_handler #(
    parameter int DOUBLEWORD_WIDTH = 64,
    parameter int DATA_MEMORY_SIZE = 1024,
    parameter int ADDR_WIDTH_DM    = $clog2(DATA_MEMORY_SIZE),
    parameter int DATA_TYPE_WIDTH  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    dm_write_handler_if.slave  wr_if,
    output logic               dbg_state
`ifdef DM_WR_ALIGN_CHECK_EN
    ,
    output logic               wr_misalign
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [DOUBLEWORD_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH_DM-1:0]    addr_q, addr_d;
    logic [2:0]                  last_idx_q, last_idx_d;
    logic [2:0]                  k_q, k_d;
    logic                        wr_idle_q, wr_idle_d;
    logic                        mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_WIDTH_DM-1:0]    mem_addr_q, mem_addr_d;
    logic [7:0]                  mem_wdata_q, mem_wdata_d;
    logic                        last_wr_q, last_wr_d;
    logic                        wr_done_q, wr_done_d;
`ifdef DM_WR_ALIGN_CHECK_EN
    logic                        misalign_q, misalign_d;
`endif

    // Index of the last byte of the incoming request (N-1).
    logic [3:0] n_in;
    logic [2:0] last_idx_in;
    assign n_in        = 4'd1 << wr_if.data_type_wr;
    assign last_idx_in = 3'(n_in - 4'd1);

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        addr_d      = addr_q;
        last_idx_d  = last_idx_q;
        k_d         = k_q;
        mem_wr_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        last_wr_d   = 1'b0;
        wr_done_d   = last_wr_q;  // pulse the cycle after the last byte write
`ifdef DM_WR_ALIGN_CHECK_EN
        misalign_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (wr_if.wr_ins) begin
`ifdef DM_WR_ALIGN_CHECK_EN
                    if (|(wr_if.addr_wr[2:0] & last_idx_in)) begin
                        misalign_d = 1'b1;  // rejected: stay idle, no write
                    end else
`endif
                    begin
                        data_d     = wr_if.data_bus_wr;
                        addr_d     = wr_if.addr_wr;
                        last_idx_d = last_idx_in;
                        k_d        = 3'd0;
                        state_d    = WRITE;
                    end
                end
            end
            WRITE: begin
                mem_wr_en_d = 1'b1;
                // Natural truncation gives the wrap at the top of memory.
                mem_addr_d  = addr_q + ADDR_WIDTH_DM'(k_q);
                mem_wdata_d = data_q[{k_q, 3'b000} +: 8];
                k_d         = k_q + 3'd1;
                if (k_q == last_idx_q) begin
                    state_d   = IDLE;
                    last_wr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        wr_idle_d = (state_d == IDLE);
    end

    // State and output registers; reset abandons any store in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            addr_q      <= '0;
            last_idx_q  <= '0;
            k_q         <= '0;
            wr_idle_q   <= 1'b1;
            mem_wr_en_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            last_wr_q   <= 1'b0;
            wr_done_q   <= 1'b0;
`ifdef DM_WR_ALIGN_CHECK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            last_idx_q  <= last_idx_d;
            k_q         <= k_d;
            wr_idle_q   <= wr_idle_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            last_wr_q   <= last_wr_d;
            wr_done_q   <= wr_done_d;
`ifdef DM_WR_ALIGN_CHECK_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    assign wr_if.wr_idle   = wr_idle_q;
    assign wr_if.mem_wr_en = mem_wr_en_q;
    assign wr_if.mem_addr  = mem_addr_q;
    assign wr_if.mem_wdata = mem_wdata_q;
    assign wr_if.wr_done   = wr_done_q;
    assign dbg_state       = state_q;
`ifdef DM_WR_ALIGN_CHECK_EN
    assign wr_misalign     = misalign_q;
`endif

endmodule

// File: tb/tb_dm_write_handler.sv
// Bench for dm_write_handler: directed stores plus a few random ones; every
// expected RAM byte write is queued when the store is driven and compared
// when the handler presents it.
module tb_dm_write_handler;

    logic clk;
    logic rst_n;
    logic dbg_state;
`ifdef DM_WR_ALIGN_CHECK_EN
    logic wr_misalign;
`endif

    dm_write_handler_if #(
        .DOUBLEWORD_WIDTH(64),
        .ADDR_WIDTH_DM   (10),
        .DATA_TYPE_WIDTH (2)
    ) bus ();

    dm_write_handler #(
        .DOUBLEWORD_WIDTH(64),
        .DATA_MEMORY_SIZE(1024),
        .ADDR_WIDTH_DM   (10),
        .DATA_TYPE_WIDTH (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_if      (bus),
        .dbg_state  (dbg_state)
`ifdef DM_WR_ALIGN_CHECK_EN
        ,
        .wr_misalign(wr_misalign)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    // Entry: {last, addr[9:0], data[7:0]}
    logic [18:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        done_exp = 1'b0;
    int          wr_count = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: compares every presented RAM write and the wr_done pulse.
    always @(negedge clk) begin
        logic [18:0] item;
        if (rst_n) begin
            if (bus.wr_done || done_exp) check("wr_done", bus.wr_done, done_exp);
            done_exp = 1'b0;
            if (bus.mem_wr_en) begin
                check("write_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    item = exp_q.pop_front();
                    check("mem_addr", bus.mem_addr, item[17:8]);
                    check("mem_wdata", bus.mem_wdata, item[7:0]);
                    check("wr_idle_on_write", bus.wr_idle, item[18]);
                    done_exp = item[18];
                    wr_count++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_store(input logic [63:0] data, input logic [9:0] addr, input logic [1:0] dt);
        int          n;
        logic [9:0]  a;
        logic [63:0] d;
        n = 1 << dt;
        d = data;
        for (int k = 0; k < n; k++) begin
            a = addr + 10'(k);
            exp_q.push_back({(k == n - 1), a, d[8*k +: 8]});
        end
    endtask

    function automatic logic is_misaligned(input logic [9:0] addr, input logic [1:0] dt);
`ifdef DM_WR_ALIGN_CHECK_EN
        return (int'(addr) % (1 << dt)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Drive one request for one accept edge; called just after a negedge.
    task automatic store(input logic [63:0] data, input logic [9:0] addr, input logic [1:0] dt);
        logic mis;
        mis = is_misaligned(addr, dt);
        bus.data_bus_wr  = data;
        bus.addr_wr      = addr;
        bus.data_type_wr = dt;
        bus.wr_ins       = 1'b1;
        if (!mis) push_store(data, addr, dt);
        @(negedge clk);
        bus.wr_ins      = 1'b0;
        bus.data_bus_wr = {$urandom, $urandom};  // must be ignored
        bus.addr_wr     = 10'($urandom);
`ifdef DM_WR_ALIGN_CHECK_EN
        #1;
        check("wr_misalign", wr_misalign, mis);
        if (mis) begin
            check("misalign_stays_idle", bus.wr_idle, 1'b1);
            @(negedge clk);
            #1;
            check("wr_misalign_clear", wr_misalign, 1'b0);
        end
`endif
    endtask

    // Wait until all expected writes and the done pulse have been seen.
    task automatic drain();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && !done_exp && bus.wr_idle && !bus.wr_done) && n < 60) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("drain_timeout", 64'(n < 60), 64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wr_idle"}, bus.wr_idle, 1'b1);
        check({tag, "_mem_wr_en"}, bus.mem_wr_en, 1'b0);
        check({tag, "_mem_addr"}, bus.mem_addr, 10'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 8'd0);
        check({tag, "_wr_done"}, bus.wr_done, 1'b0);
        check({tag, "_state"}, dbg_state, 1'b0);
`ifdef DM_WR_ALIGN_CHECK_EN
        check({tag, "_wr_misalign"}, wr_misalign, 1'b0);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int c0;
        rst_n            = 1'b0;
        bus.data_bus_wr  = '0;
        bus.addr_wr      = '0;
        bus.data_type_wr = '0;
        bus.wr_ins       = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        #2;

        // Doubleword, aligned.
        store(64'h8877665544332211, 10'h010, 2'd3);
        drain();

        // Halfword across the top of memory (rejected when alignment is checked).
        store(64'hFFFF_0000_1234_ABCD, 10'h3FF, 2'd1);
        drain();

        // Word across the top of memory.
        store(64'h0000_0000_DEAD_BEEF, 10'h3FE, 2'd2);
        drain();

        // wr_ins held through a word store with data changed mid-store.
        bus.data_bus_wr  = 64'h0000_0000_A1A2_A3A4;
        bus.addr_wr      = 10'h020;
        bus.data_type_wr = 2'd2;
        bus.wr_ins       = 1'b1;
        push_store(64'h0000_0000_A1A2_A3A4, 10'h020, 2'd2);
        @(negedge clk);
        bus.data_bus_wr = 64'h0000_0000_B1B2_B3B4;
        bus.addr_wr     = 10'h030;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!bus.wr_idle && n < 20);
        check("hold_idle_timeout", 64'(n < 20), 64'd1);
        push_store(64'h0000_0000_B1B2_B3B4, 10'h030, 2'd2);
        @(negedge clk);
        bus.wr_ins = 1'b0;
        #1;
        check("b2b_accepted", bus.wr_idle, 1'b0);
        @(negedge clk);
        #2;
        check("b2b_first_write", bus.mem_wr_en, 1'b1);
        drain();

        // Reset after three bytes of a doubleword.
        c0 = wr_count;
        store(64'hF8F7F6F5F4F3F2F1, 10'h100, 2'd3);
        n = 0;
        while (wr_count < c0 + 3 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("pre_reset_timeout", 64'(n < 20), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        exp_q.delete();
        done_exp = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #2;
        store(64'h0000_0000_0000_005A, 10'h155, 2'd0);
        drain();

        // Misaligned word then aligned word.
        store(64'h0000_0000_4433_2211, 10'h006, 2'd2);
        drain();
        store(64'h0000_0000_8877_6655, 10'h008, 2'd2);
        drain();

        // Random stores.
        for (int i = 0; i < 8; i++) begin
            store({$urandom, $urandom}, 10'($urandom_range(0, 1023)), 2'($urandom_range(0, 3)));
            drain();
        end

        repeat (3) @(negedge clk);
        #2;
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
